wb_slave_mem: RTL and testbench



---
 rtl/wb_slave_mem.sv | 100 ++++++++++
 tb/tb_wb_slave_mem.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem.sv
// Pipelined Wishbone B4 slave over a word-addressed RAM; fixed ack latency READ_LATENCY, stall_o at MAX_OUTSTANDING in flight.
// Optional WB_SLAVE_RANDOM_STALL_EN adds LFSR-driven random stalls (25%) for master stress.
module wb_slave_mem #(
    parameter int ADDR_W          = 10,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic [3:0]  sel_i,
    input  logic [2:0]  cti_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        stall_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]             mem [2**ADDR_W];
    logic [ADDR_W-1:0]       word_idx;
    logic                    accept;
    logic                    stall_cnt;
    logic [CW-1:0]           outstanding_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [31:0]             dat_q [READ_LATENCY];

    // Cycle type and sub-word address bits do not affect service.
    logic unused_bits;
    assign unused_bits = ^{cti_i, addr_i[31:ADDR_W+2], addr_i[1:0]};

    assign word_idx  = addr_i[ADDR_W+1:2];
    assign stall_cnt = (outstanding_q == CW'(MAX_OUTSTANDING));

`ifdef WB_SLAVE_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall_o = stall_cnt || (lfsr_q[1:0] == 2'b00);
`else
    assign stall_o = stall_cnt;
`endif

    assign accept = cyc_i && stb_i && !stall_o;
    assign ack_o  = vld_q[READ_LATENCY-1];
    assign data_o = dat_q[READ_LATENCY-1];

    // RAM is deliberately not reset so contents survive a mid-burst reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && rst_i) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_i[n]) begin
                    mem[word_idx][8*n +: 8] <= data_i[8*n +: 8];
                end
            end
        end
    end

    // Data stages only advance behind a valid, so the last stage holds between acks.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q         <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else if (!cyc_i) begin
            vld_q         <= '0;
            outstanding_q <= '0;
        end else begin
            vld_q[0] <= accept;
            if (accept) begin
                dat_q[0] <= we_i ? 32'h0 : mem[word_idx];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
            case ({accept, ack_o})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Random Wishbone master against wb_slave_mem with a scoreboard: accepts push expected
// (data, ack cycle) into a queue, a negedge monitor pops on every ack and checks stall_o each cycle.
module tb_wb_slave_mem;

    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int MAXO  = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [3:0]  sel_i = '0;
    logic [2:0]  cti_i = '0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic        stall_o;

    wb_slave_mem #(.ADDR_W(AW), .READ_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .sel_i(sel_i), .cti_i(cti_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .ack_o(ack_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [int];
    int          cyc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_dat = '0;
    int          pool[16];

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    // Monitor: stall_o must equal "queue full", every ack pops in order at its due cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            last_dat = '0;
        end else begin
            n_checks++;
            if (stall_o !== (sb.size() == MAXO)) begin
                n_fail++;
                $display("FAIL stall: got %b expected %b (outstanding %0d)", stall_o, sb.size() == MAXO, sb.size());
            end
            if (ack_o === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_ack: ack_o=1 with nothing outstanding at cycle %0d", cyc_cnt);
                end else begin
                    e = sb.pop_front();
                    if (data_o !== e.dat) begin
                        n_fail++;
                        $display("FAIL ack_data: got %h expected %h", data_o, e.dat);
                    end
                    n_checks++;
                    if (cyc_cnt != e.cyc) begin
                        n_fail++;
                        $display("FAIL ack_latency: ack at cycle %0d expected cycle %0d", cyc_cnt, e.cyc);
                    end
                end
                last_dat = data_o;
            end else begin
                n_checks++;
                if (ack_o !== 1'b0 || data_o !== last_dat) begin
                    n_fail++;
                    $display("FAIL idle_hold: ack %b data %h expected ack 0 data %h", ack_o, data_o, last_dat);
                end
            end
        end
    end

    task automatic drive_idle(input logic keep_cyc);
        @(negedge clk_i);
        #2;
        cyc_i = keep_cyc;
        stb_i = 1'b0;
        if (!keep_cyc) sb.delete();
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel);
        bit   done = 0;
        int   idx;
        exp_t e;
        logic [2:0] ctis [3] = '{3'b000, 3'b010, 3'b111};
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk_i);
            #2;
            cyc_i  = 1'b1;
            stb_i  = 1'b1;
            we_i   = we;
            addr_i = addr;
            data_i = dat;
            sel_i  = sel;
            cti_i  = ctis[$urandom_range(0, 2)];
            #1;
            if (!stall_o) begin
                done = 1;
                idx  = int'((addr >> 2) % DEPTH);
                if (we) begin
                    e.dat = 32'h0;
                    if (!mdl.exists(idx)) mdl[idx] = 32'h0;
                    for (int n = 0; n < 4; n++)
                        if (sel[n]) mdl[idx][8*n +: 8] = dat[8*n +: 8];
                end else begin
                    e.dat = mdl.exists(idx) ? mdl[idx] : 32'hx;
                end
                e.cyc = cyc_cnt + LAT;
                sb.push_back(e);
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: request to %h never accepted", addr);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        int          idx;

        #1 rst_i = 1'b0;
        #2;
        n_checks += 3;
        if (ack_o !== 1'b0)   begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b1;

        // Single write then read back.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'hF);
        drive_idle(1'b1);
        // Byte-lane merge.
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_req(1'b0, 32'h20, 32'h0, 4'hF);
        drive_idle(1'b1);
        // Eight back-to-back, stall throttles to MAXO in flight.
        for (int i = 0; i < 8; i++) do_req(i[0], 32'h40 + 32'(i * 4), $urandom(), 4'hF);
        repeat (4) drive_idle(1'b1);
        // Aliasing beyond the RAM depth, with a sub-word offset.
        do_req(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF);
        do_req(1'b0, 32'(4 << AW) | 32'h3, 32'h0, 4'hF);
        repeat (3) drive_idle(1'b1);
        // Abort: drop cyc right after the second read is accepted.
        do_req(1'b0, 32'h10, 32'h0, 4'hF);
        do_req(1'b0, 32'h20, 32'h0, 4'hF);
        drive_idle(1'b0);
        repeat (3) drive_idle(1'b0);
        do_req(1'b0, 32'h0, 32'h0, 4'hF);
        repeat (3) drive_idle(1'b1);
        // Reset with two outstanding; RAM must survive.
        do_req(1'b0, 32'h10, 32'h0, 4'hF);
        do_req(1'b0, 32'h20, 32'h0, 4'hF);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        sb.delete();
        #1;
        n_checks += 2;
        if (ack_o !== 1'b0)   begin n_fail++; $display("FAIL midreset_ack: got %b expected 0", ack_o); end
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b expected 0", stall_o); end
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, 4'hF);
        do_req(1'b0, 32'h20, 32'h0, 4'hF);
        repeat (3) drive_idle(1'b1);

        // Random traffic over a prefilled address pool.
        for (int i = 0; i < 16; i++) begin
            pool[i] = $urandom_range(16, DEPTH - 1);
            do_req(1'b1, 32'(pool[i] << 2), $urandom(), 4'hF);
        end
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                drive_idle(1'b0);
            end else if (r < 4) begin
                drive_idle(1'b1);
            end else begin
                idx = pool[$urandom_range(0, 15)];
                a   = ($urandom() << (AW + 2)) | 32'(idx << 2) | 32'($urandom_range(0, 3));
                do_req(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
            end
        end
        repeat (LAT + 4) drive_idle(1'b1);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d requests never acked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
